or1200_enc_engine_arb: RTL and testbench

Arbiter and sequencer that shares one encryption engine between the LOAD and STORE pad paths of the OR1200 encryption unit. Each path raises a seed request. The arbiter grants one path round-robin, forms the 128-bit engine input block, starts the engine and waits for completion. It then captures the 128-bit pad into a per-path pad register and pulses that path's done signal. It sits between the seed-decode logic and the encryption engine, and feeds the pad-shift modules.

---
 rtl/or1200_enc_arb_pkg.sv | 36 +++
 rtl/or1200_enc_engine_arb_if.sv | 49 ++++
 rtl/or1200_enc_arb_wdog.sv | 31 +++
 rtl/or1200_enc_engine_arb.sv | 140 ++++++++++++++
 tb/tb_or1200_enc_engine_arb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/or1200_enc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : or1200_enc_arb_pkg
// Shared state/channel encodings and block widths for the engine arbiter.
// Rev    : 1.0
// ============================================================================
package or1200_enc_arb_pkg;

  localparam int C_BLK_W  = 128;
  localparam int C_SEED_W = 32;
  localparam int C_ADDR_W = 5;
  localparam int C_IMM_W  = 11;
  localparam int C_ZERO_W = C_BLK_W - C_IMM_W - C_ADDR_W - C_SEED_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  typedef enum logic {
    CH_LOAD  = 1'b0,
    CH_STORE = 1'b1
  } ch_t;

  function automatic logic [C_BLK_W-1:0] make_blk(
    input logic [C_IMM_W-1:0]  imm,
    input logic [C_ADDR_W-1:0] addr,
    input logic [C_SEED_W-1:0] seed
  );
    return {{C_ZERO_W{1'b0}}, imm, addr, seed};
  endfunction

endpackage
`default_nettype wire

// File: rtl/or1200_enc_engine_arb_if.sv
`default_nettype none
// ============================================================================
// Module : or1200_enc_engine_arb_if
// Request, engine and pad-delivery signals of the encryption-engine arbiter.
// Rev    : 1.0
// ============================================================================
interface or1200_enc_engine_arb_if;
  import or1200_enc_arb_pkg::*;

  logic                req_load;
  logic                req_store;
  logic [C_SEED_W-1:0] seed_in_load;
  logic [C_SEED_W-1:0] seed_in_store;
  logic [C_ADDR_W-1:0] seed_addr_load;
  logic [C_ADDR_W-1:0] seed_addr_store;
  logic [C_IMM_W-1:0]  seed_imm_load;
  logic [C_IMM_W-1:0]  seed_imm_store;
  logic                ack_load;
  logic                ack_store;
  logic                eng_start;
  logic [C_BLK_W-1:0]  eng_blk;
  logic                eng_done;
  logic [C_BLK_W-1:0]  eng_out;
  logic [C_BLK_W-1:0]  pad_load;
  logic [C_BLK_W-1:0]  pad_store;
  logic                done_load;
  logic                done_store;
  logic                err_load;
  logic                err_store;
  logic                busy;

  modport master (
    input  req_load, req_store, seed_in_load, seed_in_store,
           seed_addr_load, seed_addr_store, seed_imm_load, seed_imm_store,
           eng_done, eng_out,
    output ack_load, ack_store, eng_start, eng_blk, pad_load, pad_store,
           done_load, done_store, err_load, err_store, busy
  );

  modport slave (
    output req_load, req_store, seed_in_load, seed_in_store,
           seed_addr_load, seed_addr_store, seed_imm_load, seed_imm_store,
           eng_done, eng_out,
    input  ack_load, ack_store, eng_start, eng_blk, pad_load, pad_store,
           done_load, done_store, err_load, err_store, busy
  );

endinterface
`default_nettype wire

// File: rtl/or1200_enc_arb_wdog.sv
`default_nettype none
// ============================================================================
// Module : or1200_enc_arb_wdog
// WAIT-state timeout counter; used only with OR1200_ENC_ARB_WATCHDOG_EN.
// Rev    : 1.0
// ============================================================================
module or1200_enc_arb_wdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Count starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks the last one.
  assign expire = en && (r_cnt == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/or1200_enc_engine_arb.sv
`default_nettype none
// ============================================================================
// Module : or1200_enc_engine_arb
// Round-robin LOAD/STORE arbiter sequencing one shared encryption engine.
// Optional WAIT watchdog: define OR1200_ENC_ARB_WATCHDOG_EN.
// Rev    : 1.0
// ============================================================================
module or1200_enc_engine_arb
  import or1200_enc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  wire logic               clk,
  input  wire logic               rst,
  or1200_enc_engine_arb_if.master bus
);

  state_t              r_state;
  state_t              w_next;
  ch_t                 r_rr;
  ch_t                 r_ch;
  ch_t                 w_gnt_ch;
  logic                w_grant;
  logic                w_wd_expire;
  logic                w_err;
  logic [C_BLK_W-1:0]  r_blk;
  logic [C_BLK_W-1:0]  r_pad_load;
  logic [C_BLK_W-1:0]  r_pad_store;
  logic [C_BLK_W-1:0]  w_blk;

  always_comb begin
    w_gnt_ch = CH_LOAD;
    if (bus.req_load && bus.req_store) begin
      w_gnt_ch = r_rr;
    end else if (bus.req_store) begin
      w_gnt_ch = CH_STORE;
    end
  end

  assign w_grant = (r_state == IDLE) && !rst && (bus.req_load || bus.req_store);
  assign w_blk   = (w_gnt_ch == CH_STORE)
                 ? make_blk(bus.seed_imm_store, bus.seed_addr_store, bus.seed_in_store)
                 : make_blk(bus.seed_imm_load,  bus.seed_addr_load,  bus.seed_in_load);

  always_comb begin
    w_next         = r_state;
    bus.ack_load   = 1'b0;
    bus.ack_store  = 1'b0;
    bus.eng_start  = 1'b0;
    bus.done_load  = 1'b0;
    bus.done_store = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next        = ISSUE;
          bus.ack_load  = (w_gnt_ch == CH_LOAD);
          bus.ack_store = (w_gnt_ch == CH_STORE);
        end
      end
      ISSUE: begin
        bus.eng_start = !rst;
        w_next        = WAIT;
      end
      WAIT: begin
        if (bus.eng_done || w_wd_expire) begin
          w_next = DELIVER;
        end
      end
      DELIVER: begin
        bus.done_load  = !rst && (r_ch == CH_LOAD);
        bus.done_store = !rst && (r_ch == CH_STORE);
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr        <= CH_LOAD;
      r_ch        <= CH_LOAD;
      r_blk       <= '0;
      r_pad_load  <= '0;
      r_pad_store <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_ch  <= w_gnt_ch;
        r_rr  <= (w_gnt_ch == CH_LOAD) ? CH_STORE : CH_LOAD;
        r_blk <= w_blk;
      end
      if ((r_state == WAIT) && bus.eng_done) begin
        if (r_ch == CH_LOAD) begin
          r_pad_load <= bus.eng_out;
        end else begin
          r_pad_store <= bus.eng_out;
        end
      end
    end
  end

`ifdef OR1200_ENC_ARB_WATCHDOG_EN
  logic r_err;

  or1200_enc_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (r_state == ISSUE),
    .en     (r_state == WAIT),
    .expire (w_wd_expire)
  );

  // A completion in the expiry cycle wins over the abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == WAIT) begin
      r_err <= w_wd_expire && !bus.eng_done;
    end
  end

  assign w_err = r_err;
`else
  // TIMEOUT is at least 2, so without the watchdog this never expires.
  assign w_wd_expire = (TIMEOUT == 0);
  assign w_err       = 1'b0;
`endif

  assign bus.err_load  = bus.done_load && w_err;
  assign bus.err_store = bus.done_store && w_err;
  assign bus.eng_blk   = r_blk;
  assign bus.pad_load  = r_pad_load;
  assign bus.pad_store = r_pad_store;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_or1200_enc_engine_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_or1200_enc_engine_arb
// Scoreboard bench for the engine arbiter: random requests, engine model.
// Rev    : 1.0
// ============================================================================
module tb_or1200_enc_engine_arb;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  or1200_enc_engine_arb_if bus ();

  or1200_enc_engine_arb #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Engine behaviour knobs (written by main only).
  int force_lat = 0;
  bit silent    = 1'b0;
  int stray_cnt = 0;

  // Scoreboard queues.
  logic [127:0] q_blk[$];
  logic [127:0] q_pad[$];

  // Reference model state (monitor only).
  bit           inflight = 1'b0;
  bit           rr       = 1'b0;
  bit           cur_ch   = 1'b0;
  bit           rst_d    = 1'b0;
  bit           exp_err  = 1'b0;
  int           ack_cyc  = 0;
  int           done_cyc = -1;
  logic [127:0] exp_pad_load  = '0;
  logic [127:0] exp_pad_store = '0;

  // Observed event cycles, for directed timing checks.
  int obs_ack_load   = 0;
  int obs_ack_store  = 0;
  int obs_done_load  = 0;
  int obs_done_store = 0;
  bit obs_err_store  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: sample acks mid-cycle, then release acked requests.
  task automatic tick();
    logic al, as;
    @(negedge clk);
    al = bus.ack_load;
    as = bus.ack_store;
    @(posedge clk);
    #1;
    if (al) bus.req_load = 1'b0;
    if (as) bus.req_store = 1'b0;
  endtask

  task automatic raise(input bit ch, input logic [31:0] s, input logic [4:0] a, input logic [10:0] im);
    if (ch) begin
      bus.req_store = 1'b1; bus.seed_in_store = s; bus.seed_addr_store = a; bus.seed_imm_store = im;
    end else begin
      bus.req_load = 1'b1; bus.seed_in_load = s; bus.seed_addr_load = a; bus.seed_imm_load = im;
    end
  endtask

  // Engine model: answers each start after N cycles with a random result.
  initial begin : engine
    int           n;
    int           seen_stray;
    logic [127:0] v;
    seen_stray   = 0;
    bus.eng_done = 1'b0;
    bus.eng_out  = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt != seen_stray) begin
        seen_stray = stray_cnt;
        @(posedge clk); #1;
        bus.eng_out  = {$urandom, $urandom, $urandom, $urandom};
        bus.eng_done = 1'b1;
        @(posedge clk); #1;
        bus.eng_done = 1'b0;
      end else if (bus.eng_start && !rst && !silent) begin
        n = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
        repeat (n) @(posedge clk);
        #1;
        v = {$urandom, $urandom, $urandom, $urandom};
        if (!rst) begin
          bus.eng_out  = v;
          bus.eng_done = 1'b1;
          q_pad.push_back(v);
        end
        @(posedge clk); #1;
        bus.eng_done = 1'b0;
      end
    end
  end

  // Monitor with a transaction-level reference: one job in flight, round-robin
  // choice on contention, done one cycle after the engine answers.
  initial begin : monitor
    bit granted;
    bit g;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.ack_load)  obs_ack_load  = cyc;
      if (bus.ack_store) obs_ack_store = cyc;
      if (bus.done_load) obs_done_load = cyc;
      if (bus.done_store) begin
        obs_done_store = cyc;
        obs_err_store  = bus.err_store;
      end
      if (rst) begin
        if (rst_d) begin
          chk("rst_busy", bus.busy, 0);
          chk("rst_start", bus.eng_start, 0);
          chk("rst_acks", {bus.ack_load, bus.ack_store}, 0);
          chk("rst_done_err", {bus.done_load, bus.done_store, bus.err_load, bus.err_store}, 0);
          chk("rst_blk", bus.eng_blk, 0);
          chk("rst_pad_load", bus.pad_load, 0);
          chk("rst_pad_store", bus.pad_store, 0);
        end
        rst_d = 1'b1; inflight = 1'b0; rr = 1'b0; done_cyc = -1; exp_err = 1'b0;
        exp_pad_load = '0; exp_pad_store = '0;
        q_blk.delete(); q_pad.delete();
      end else begin
        rst_d   = 1'b0;
        granted = 1'b0;
        g       = 1'b0;
        if (!inflight && (bus.req_load || bus.req_store)) begin
          granted  = 1'b1;
          g        = (bus.req_load && bus.req_store) ? rr : bus.req_store;
          rr       = !g;
          cur_ch   = g;
          inflight = 1'b1;
          ack_cyc  = cyc;
          q_blk.push_back(g ? {80'b0, bus.seed_imm_store, bus.seed_addr_store, bus.seed_in_store}
                            : {80'b0, bus.seed_imm_load,  bus.seed_addr_load,  bus.seed_in_load});
        end
        chk("ack_load", bus.ack_load, granted && !g);
        chk("ack_store", bus.ack_store, granted && g);
        chk("busy", bus.busy, inflight && (cyc > ack_cyc));
        chk("eng_start", bus.eng_start, inflight && (cyc == ack_cyc + 1));
        if (inflight && (cyc == ack_cyc + 1)) begin
          chk("blk_queue", q_blk.size() > 0, 1);
          if (q_blk.size() > 0) chk("eng_blk", bus.eng_blk, q_blk.pop_front());
        end
        if (bus.eng_done && inflight && (cyc >= ack_cyc + 2) && (done_cyc < 0)) begin
          done_cyc = cyc + 1;
        end
`ifdef OR1200_ENC_ARB_WATCHDOG_EN
        if (inflight && (done_cyc < 0) && (cyc == ack_cyc + 1 + int'(TO))) begin
          done_cyc = cyc + 1;
          exp_err  = 1'b1;
        end
`endif
        chk("done_load", bus.done_load, (cyc == done_cyc) && !cur_ch);
        chk("done_store", bus.done_store, (cyc == done_cyc) && cur_ch);
        if (cyc == done_cyc) begin
          if (!exp_err) begin
            chk("pad_queue", q_pad.size() > 0, 1);
            if (q_pad.size() > 0) begin
              if (cur_ch) exp_pad_store = q_pad.pop_front();
              else        exp_pad_load  = q_pad.pop_front();
            end
          end
          chk("err_load", bus.err_load, exp_err && !cur_ch);
          chk("err_store", bus.err_store, exp_err && cur_ch);
          inflight = 1'b0; done_cyc = -1; exp_err = 1'b0;
        end else begin
          chk("err_idle", {bus.err_load, bus.err_store}, 0);
        end
        chk("pad_load", bus.pad_load, exp_pad_load);
        chk("pad_store", bus.pad_store, exp_pad_store);
      end
    end
  end

  initial begin : main
    bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.seed_in_load = '0; bus.seed_addr_load = '0; bus.seed_imm_load = '0;
    bus.seed_in_store = '0; bus.seed_addr_store = '0; bus.seed_imm_store = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Contention from reset: load first, store N+3 later; again after that.
    force_lat = 2;
    raise(1'b0, 32'h1111_0001, 5'd1, 11'h011);
    raise(1'b1, 32'h2222_0002, 5'd2, 11'h022);
    repeat (14) tick();
    chk("pair1_spacing", obs_ack_store - obs_ack_load, 5);
    raise(1'b0, 32'h3333_0003, 5'd4, 11'h033);
    raise(1'b1, 32'h4444_0004, 5'd8, 11'h044);
    repeat (14) tick();
    chk("pair2_spacing", obs_ack_store - obs_ack_load, 5);

    // Single load with N=4, plus a store request arriving during WAIT.
    force_lat = 4;
    raise(1'b0, 32'hDEADBEEF, 5'd3, 11'h400);
    repeat (3) tick();
    raise(1'b1, 32'hCAFE_F00D, 5'd7, 11'h123);
    repeat (18) tick();
    chk("load_latency", obs_done_load - obs_ack_load, 6);
    chk("wait_req_ack", obs_ack_store - obs_ack_load, 7);

    // Random traffic, including requests withdrawn before their ack.
    force_lat = 0;
    repeat (500) begin
      tick();
      if (!bus.req_load && $urandom_range(0, 3) == 0)
        raise(1'b0, $urandom, 5'($urandom), 11'($urandom));
      else if (bus.req_load && $urandom_range(0, 39) == 0)
        bus.req_load = 1'b0;
      if (!bus.req_store && $urandom_range(0, 3) == 0)
        raise(1'b1, $urandom, 5'($urandom), 11'($urandom));
      else if (bus.req_store && $urandom_range(0, 39) == 0)
        bus.req_store = 1'b0;
    end
    repeat (40) tick();
    chk("drain_blk_q", q_blk.size(), 0);
    chk("drain_pad_q", q_pad.size(), 0);

    // Reset while waiting on a silent engine, then a stray engine completion.
    silent = 1'b1;
    raise(1'b0, $urandom, 5'd9, 11'h055);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    stray_cnt++;
    repeat (6) tick();

`ifdef OR1200_ENC_ARB_WATCHDOG_EN
    raise(1'b1, $urandom, 5'd10, 11'h066);
    repeat (14) tick();
    chk("wdog_abort_time", obs_done_store - obs_ack_store, 2 + TO);
    chk("wdog_abort_err", obs_err_store, 1);
    silent    = 1'b0;
    force_lat = int'(TO);
    raise(1'b1, $urandom, 5'd11, 11'h077);
    repeat (16) tick();
    chk("wdog_edge_time", obs_done_store - obs_ack_store, 2 + TO);
    chk("wdog_edge_err", obs_err_store, 0);
`else
    raise(1'b1, $urandom, 5'd10, 11'h066);
    repeat (1000) tick();
    chk("silent_busy", bus.busy, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
